// File: rtl/sdram_wb_arbiter.sv
// rtl/sdram_wb_arbiter.sv - round-robin Wishbone arbiter in front of the SDR SDRAM controller
// Optional feature macro: ARB_PORT0_PRIO_EN (port 0 overrides round-robin when idle)
module sdram_wb_arbiter #(
  parameter int nr_ports  = 4,
  parameter int adr_width = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [32*nr_ports-1:0]          m_dat_i,
  input  logic [adr_width*nr_ports-1:0]   m_adr_i,
  input  logic [4*nr_ports-1:0]           m_sel_i,
  input  logic [2*nr_ports-1:0]           m_bte_i,
  input  logic [nr_ports-1:0]             m_we_i,
  input  logic [nr_ports-1:0]             m_cyc_i,
  input  logic [nr_ports-1:0]             m_stb_i,
  output logic [31:0]                     m_dat_o,
  output logic [nr_ports-1:0]             m_ack_o,
  output logic [31:0]                     s_dat_o,
  output logic [adr_width-1:0]            s_adr_o,
  output logic [3:0]                      s_sel_o,
  output logic [1:0]                      s_bte_o,
  output logic                            s_we_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  input  logic [31:0]                     s_dat_i,
  input  logic                            s_ack_i,
  output logic [nr_ports-1:0]             grant_o
);

  localparam int pw = $clog2(nr_ports);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t              state, state_nxt;
  logic [nr_ports-1:0] grant_nxt;
  logic [pw-1:0]       owner, owner_nxt;
  logic [pw-1:0]       last_port, last_nxt;
  logic [pw-1:0]       win, hi_win, lo_win;
  logic                hi_found, win_upd;

  // Round-robin pick: lowest requester above last_port, else lowest requester overall (wrap)
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    for (int k = nr_ports - 1; k >= 0; k--) begin
      if (m_cyc_i[k] && (k > int'(last_port))) begin
        hi_found = 1'b1;
        hi_win   = pw'(k);
      end
      if (m_cyc_i[k]) begin
        lo_win = pw'(k);
      end
    end
    win     = hi_found ? hi_win : lo_win;
    win_upd = 1'b1;
`ifdef ARB_PORT0_PRIO_EN
    // Port 0 jumps the queue without disturbing the rotation of the others
    if (m_cyc_i[0]) begin
      win     = '0;
      win_upd = 1'b0;
    end
`endif
  end

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_o   <= '0;
      owner     <= '0;
      last_port <= pw'(nr_ports - 1);
    end else begin
      state     <= state_nxt;
      grant_o   <= grant_nxt;
      owner     <= owner_nxt;
      last_port <= last_nxt;
    end
  end

  // Next-state logic: hold ownership for the whole cycle, then one GAP cycle
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    owner_nxt = owner;
    last_nxt  = last_port;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt = GRANT;
          owner_nxt = win;
          grant_nxt = {{(nr_ports-1){1'b0}}, 1'b1} << win;
          if (win_upd) last_nxt = win;
        end
      end
      GRANT: begin
        if (!m_cyc_i[owner]) begin
          state_nxt = GAP;
          grant_nxt = '0;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-side mux and ack gating, active only while a port owns the bus
  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_bte_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    if (state == GRANT) begin
      s_dat_o = m_dat_i[32*int'(owner) +: 32];
      s_adr_o = m_adr_i[adr_width*int'(owner) +: adr_width];
      s_sel_o = m_sel_i[4*int'(owner) +: 4];
      s_bte_o = m_bte_i[2*int'(owner) +: 2];
      s_we_o  = m_we_i[owner];
      s_cyc_o = m_cyc_i[owner];
      s_stb_o = m_stb_i[owner];
      m_ack_o = grant_o & {nr_ports{s_ack_i}};
    end
  end

  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb/tb_sdram_wb_arbiter.sv - randomized self-checking bench for sdram_wb_arbiter
module tb_sdram_wb_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0][31:0] m_dat;
  logic [NP-1:0][AW-1:0] m_adr;
  logic [NP-1:0][3:0]  m_sel;
  logic [NP-1:0][1:0]  m_bte;
  logic [NP-1:0]       m_we, m_cyc, m_stb;
  logic [31:0]         m_dat_o, s_dat_o, s_dat_i;
  logic [NP-1:0]       m_ack_o, grant_o;
  logic [AW-1:0]       s_adr_o;
  logic [3:0]          s_sel_o;
  logic [1:0]          s_bte_o;
  logic                s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  int checks = 0;
  int errors = 0;
  int model_last;
  int exp_order[$];

  sdram_wb_arbiter #(.nr_ports(NP), .adr_width(AW)) dut (
    .clk(clk), .rst(rst),
    .m_dat_i(m_dat), .m_adr_i(m_adr), .m_sel_i(m_sel), .m_bte_i(m_bte),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_bte_o(s_bte_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Reference: ports of the mask are served in rotation order from the last winner
  task automatic predict(input logic [NP-1:0] mask);
    logic [NP-1:0] rem;
    int pick;
    rem = mask;
    exp_order.delete();
    while (rem != '0) begin
      pick = -1;
`ifdef ARB_PORT0_PRIO_EN
      if (rem[0]) pick = 0;
`endif
      if (pick < 0) begin
        for (int s = 1; s <= NP; s++)
          if (pick < 0 && rem[(model_last + s) % NP]) pick = (model_last + s) % NP;
        model_last = pick;
      end
      exp_order.push_back(pick);
      rem[pick] = 1'b0;
    end
  endtask

  task automatic randomize_ports();
    for (int i = 0; i < NP; i++) begin
      m_dat[i] = $urandom;
      m_adr[i] = AW'($urandom);
      m_sel[i] = 4'($urandom);
      m_bte[i] = 2'($urandom);
      m_we[i]  = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = NP - 1;
  endtask

  // Masters in mask request together, each holds cyc through random beats, then releases
  task automatic run_round(input logic [NP-1:0] mask, input int fixed_delay);
    int cnt, gap, p, d, beats, last_n;
    logic [NP-1:0] expg;
    predict(mask);
    last_n = exp_order.size() - 1;
    for (int i = 0; i < NP; i++)
      if (mask[i]) begin
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
      end
    for (int n = 0; n <= last_n; n++) begin
      p = exp_order[n];
      expg = '0;
      expg[p] = 1'b1;
      cnt = 0;
      while (grant_o == '0 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (grant_o !== expg) begin
        errors++;
        $display("FAIL grant: got %b expected %b", grant_o, expg);
      end
      if (n == 0) begin
        checks++;
        if (cnt != 1) begin
          errors++;
          $display("FAIL grant_latency: got %0d cycles expected 1", cnt);
        end
      end
      checks++;
      if (s_adr_o !== m_adr[p] || s_dat_o !== m_dat[p] || s_sel_o !== m_sel[p] ||
          s_bte_o !== m_bte[p] || s_we_o !== m_we[p] || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin
        errors++;
        $display("FAIL slave_mux port %0d: adr %h/%h dat %h/%h we %b/%b cyc %b stb %b",
                 p, s_adr_o, m_adr[p], s_dat_o, m_dat[p], s_we_o, m_we[p], s_cyc_o, s_stb_o);
      end
      beats = $urandom_range(1, 4);
      for (int b = 0; b < beats; b++) begin
        d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        s_dat_i = $urandom;
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== expg || m_dat_o !== s_dat_i) begin
          errors++;
          $display("FAIL ack_route: ack %b expected %b dat %h expected %h", m_ack_o, expg, m_dat_o, s_dat_i);
        end
        @(negedge clk);
        s_ack_i = 1'b0;
      end
      m_cyc[p] = 1'b0;
      m_stb[p] = 1'b0;
      @(negedge clk);
      gap = 0;
      while (grant_o == '0 && gap < 6) begin
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== '0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_adr_o !== '0 ||
            s_dat_o !== '0 || s_we_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: ack %b cyc %b stb %b adr %h dat %h we %b expected all 0",
                   m_ack_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_we_o);
        end
        s_ack_i = 1'b0;
        gap++;
        if (n == last_n && gap == 2) break;
        @(negedge clk);
      end
      if (n < last_n) begin
        checks++;
        if (gap != 2) begin
          errors++;
          $display("FAIL release_gap: got %0d idle cycles expected 2", gap);
        end
      end
    end
  endtask

  task automatic test_reset();
    m_cyc = '0;
    m_stb = '0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    randomize_ports();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant_o !== '0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== '0 ||
        s_we_o !== 1'b0 || s_adr_o !== '0) begin
      errors++;
      $display("FAIL reset_state: grant %b cyc %b stb %b ack %b we %b adr %h expected all 0",
               grant_o, s_cyc_o, s_stb_o, m_ack_o, s_we_o, s_adr_o);
    end
    rst = 1'b0;
    model_last = NP - 1;
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== '0) begin
      errors++;
      $display("FAIL idle_ack: got %b expected 0", m_ack_o);
    end
    s_ack_i = 1'b0;
  endtask

  task automatic test_single();
    randomize_ports();
    m_adr[2] = 24'h000123;
    m_we[2]  = 1'b0;
    m_bte[2] = 2'b00;
    run_round(4'b0100, 2);
  endtask

  task automatic test_contention();
    do_reset();
    randomize_ports();
    run_round(4'b1111, -1);
  endtask

  task automatic test_wrap();
    randomize_ports();
    run_round(4'b1010, -1);
  endtask

  task automatic test_reset_mid();
    int cnt;
    randomize_ports();
    m_we[1]  = 1'b1;
    m_bte[1] = 2'b01;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    cnt = 0;
    while (grant_o == '0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (grant_o !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_grant: got %b expected 0010", grant_o);
    end
    s_ack_i = 1'b1;
    @(negedge clk);
    s_ack_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant_o !== '0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== '0) begin
      errors++;
      $display("FAIL async_reset: grant %b cyc %b stb %b ack %b expected all 0",
               grant_o, s_cyc_o, s_stb_o, m_ack_o);
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = NP - 1;
    run_round(4'b0011, -1);
  endtask

  task automatic test_priority();
    randomize_ports();
    run_round(4'b0001, -1);
    run_round(4'b0101, -1);
  endtask

  task automatic test_random();
    logic [NP-1:0] mask;
    for (int r = 0; r < 20; r++) begin
      randomize_ports();
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      run_round(mask, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
